// File: rtl/mux_pkg.sv
// Shared types for the registered round-robin multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first asserted request at or after ptr, wrapping at N.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Outer loop walks distance from ptr, so the first hit is the fairest one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req[k] && (k == (32'(ptr) + i) % N)) begin
          found = 1'b1;
          idx   = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N:1 mux with per-channel valid/ready, manual or round-robin select,
// and a one-entry output register supporting full-throughput backpressure.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  out_state_e       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_ch_q;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             grant_ok;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [W-1:0]     grant_data;
  logic             can_accept;
  logic             xfer;

  rr_pick #(.N(N)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign can_accept = (state_q == EMPTY) | out_ready;

  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    if (mode_e'(mode) == MODE_RR) begin
      grant_ok = pick_found;
      grant    = pick_idx;
    end else begin
      grant_ok = (32'(sel) < N);
      grant    = sel;
    end
  end

  // Decode by loop so an out-of-range manual select never indexes past N.
  always_comb begin
    in_ready    = '0;
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant_ok && (grant == SEL_W'(k))) begin
        in_ready[k] = can_accept;
        grant_valid = in_valid[k];
        grant_data  = in_data[k*W +: W];
      end
    end
  end

  assign xfer = grant_valid & can_accept;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)           state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        out_data_q <= grant_data;
        out_ch_q   <= grant;
        if (mode_e'(mode) == MODE_RR)
          rr_ptr_q <= (32'(grant) == N - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised registered N:1 multiplexer. Successor to the single-select clocked mux.
- Adds per-channel valid/ready handshakes and a one-entry output register with backpressure.
- Adds two select modes: manual (external select) and round-robin (fair auto-scan across requesting channels).
- Sits between N producer channels and one downstream consumer in the datapath.

Parameters:
N, 4, number of input channels (>=2)
W, 8, data width per channel
SEL_W, $clog2(N), select/channel-index width (derived, do not override)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
mode  input  1  0 = manual select, 1 = round-robin
sel  input  SEL_W  channel index used in manual mode
in_data  input  N*W  packed channel data, channel k at [k*W +: W]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
out_data  output  W  registered selected data
out_ch  output  SEL_W  registered index of the channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  downstream accepts

Behaviour:
- Reset: rst sampled low at a rising clk edge sets out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Reset overrides any in-flight transfer; the pending output word is discarded.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready.
- Grant, combinational:
  - Manual mode: grant = sel when sel < N. When sel >= N there is no grant and all in_ready are 0.
  - Round-robin mode: grant = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
- in_ready[grant] = can_accept. All other in_ready bits are 0. In manual mode in_ready[sel] is asserted even when in_valid[sel]=0.
- Transfer occurs when in_valid[grant] & in_ready[grant]. At the next edge: out_data = in_data[grant], out_ch = grant, out_valid = 1. Latency is 1 cycle.
- Drain: on out_valid & out_ready with no new transfer, the next state is out_valid=0. out_data and out_ch hold their last values.
- Simultaneous drain and transfer: the register is overwritten, out_valid stays 1, and no bubble is inserted (full throughput, one word per cycle).
- Backpressure: while FULL and out_ready=0, all in_ready are 0 and out_data, out_ch, out_valid are stable.
- rr_ptr:
  - Updates only on a round-robin-mode transfer: rr_ptr = (grant+1) mod N, wrapping N-1 to 0.
  - Holds in manual mode.
  - A mode change takes effect at the next grant evaluation and does not reset rr_ptr.
- No valids in round-robin mode: no grant, rr_ptr holds.
- No combinational path from in_data to out_data.

Decomposition:
- Package mux_pkg: mode enum (MODE_MANUAL=0, MODE_RR=1) and the output-state enum (EMPTY, FULL).
- Sub-module rr_pick (N parameter): inputs req[N-1:0] and ptr. Outputs found and idx, giving the first request at or after ptr with wrap-around. It is purely combinational and is instantiated once by mux_rr_reg.
- Everything else lives in mux_rr_reg.

Test Plan:
- Reset mid-stream: mode=1, all 4 channels valid with data 0x10..0x13, out_ready=1. Assert rst=0 for 1 cycle after 2 transfers -> next cycle out_valid=0, out_data=0, out_ch=0, and the following transfer comes from channel 0.
- Manual select: mode=0, sel=2, in_data ch2=0xA5, in_valid=4'b1111, out_ready=1 -> 1 cycle later out_data=0xA5, out_ch=2. in_ready is 4'b0100 every cycle.
- Round-robin fairness with wrap: mode=1, in_valid=4'b1011 held, out_ready=1 -> out_ch sequence 0,1,3,0,1,3. Channel 2 is never granted.
- Backpressure: FULL with 0x3C, out_ready=0 for 5 cycles -> out_data=0x3C stable, in_ready=0. out_ready=1 with ch1 valid (0x77) -> 0x77 appears the next cycle with no bubble.
- Invalid select: mode=0, sel=3 with N=3 -> in_ready=0, out_valid stays 0.
- Mode switch: mode=1 until rr_ptr=2, then mode=0 with sel=0 for 3 transfers, then mode=1 with all valid -> first round-robin grant is channel 2.
